// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns header + burst data frames into register-bus
// write/read strobes; all SPI inputs are synchronised into the clk domain.
module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned HDR_W = 8;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q, vld_q;
  logic cs_prev_q, sclk_prev_q, armed_q, armed_d;
  logic cs_s, sclk_s, mosi_s;
  logic cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, miso_sr_q, miso_sr_d, hold_q, hold_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wr_q, wr_d, rd_q, rd_d, ferr_q, ferr_d, busy_q, busy_d, miso_q, miso_d;
  logic wr_mode_q, wr_mode_d, inc_q, inc_d, load_pend_q, load_pend_d, rd_dly_q;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // A cs_n fall only counts once a genuine high has been seen since reset.
  assign cs_fall_c   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise_c   = ~cs_prev_q & cs_s;
  assign sclk_rise_c = ~sclk_prev_q & sclk_s;
  assign sclk_fall_c = sclk_prev_q & ~sclk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      miso_sr_q   <= '0;
      hold_q      <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_mode_q   <= 1'b0;
      inc_q       <= 1'b0;
      load_pend_q <= 1'b0;
      rd_dly_q    <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      miso_sr_q   <= miso_sr_d;
      hold_q      <= hold_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      wr_mode_q   <= wr_mode_d;
      inc_q       <= inc_d;
      load_pend_q <= load_pend_d;
      rd_dly_q    <= rd_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    miso_sr_d   = miso_sr_q;
    hold_d      = hold_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    ferr_d      = 1'b0;
    wr_mode_d   = wr_mode_q;
    inc_d       = inc_q;
    load_pend_d = load_pend_q;
    armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);

    if ((wr_q | rd_q) & inc_q) addr_d = addr_q + ADDR_W'(1);
    // Read data arrives one cycle after the strobe; park it for the next fall.
    if (rd_dly_q) begin
      hold_d      = reg_rdata;
      load_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall_c) begin
          state_d     = CMD;
          cnt_d       = '0;
          miso_sr_d   = '0;
          load_pend_d = 1'b0;
        end
      end
      CMD: begin
        if (cs_rise_c) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise_c) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HDR_W - 1)) begin
            state_d   = DATA;
            cnt_d     = '0;
            wr_mode_d = shift_q[6];
            inc_d     = shift_q[5];
            addr_d    = ADDR_W'({shift_q[6:0], mosi_s});
            rd_d      = ~shift_q[6];
          end
        end
      end
      DATA: begin
        if (cs_rise_c) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
        end else begin
          if (sclk_rise_c) begin
            shift_d = {shift_q[DATA_W-2:0], mosi_s};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d = '0;
              if (wr_mode_q) begin
                wr_d    = 1'b1;
                wdata_d = {shift_q[DATA_W-2:0], mosi_s};
              end else begin
                rd_d = 1'b1;
              end
            end
          end
          if (sclk_fall_c) begin
            if (load_pend_q) begin
              miso_sr_d   = hold_q;
              load_pend_d = 1'b0;
            end else if (rd_dly_q) begin
              miso_sr_d   = reg_rdata;
              load_pend_d = 1'b0;
            end else begin
              miso_sr_d = {miso_sr_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    miso_d = (state_d == DATA) && !wr_mode_d && miso_sr_d[DATA_W-1];
  end

  assign spi_miso  = miso_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a frame-level model predicts the strobe
// sequence, MISO words and frame errors; a negedge monitor checks against it.
module tb_spi_reg_bridge;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata, reg_rdata;
  logic reg_wr, reg_rd, frame_err, busy;

  typedef struct packed {
    logic       is_wr;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_words[$];
  logic [3:0] obs_addr[$];
  logic [7:0] obs_data[$];
  int checks = 0, passes = 0, ferr_seen = 0, ferr_exp = 0;
  bit in_write = 1'b0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .frame_err(frame_err), .busy(busy)
  );

  // Register file: rdata = addr*0x11 exactly one cycle after reg_rd, junk otherwise.
  always @(posedge clk) reg_rdata <= reg_rd ? 8'(reg_addr * 8'h11) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_err) ferr_seen++;
      check("wr_rd_exclusive", 32'(reg_wr & reg_rd), 0);
      if (!busy || in_write) check("miso_quiet", 32'(spi_miso), 0);
      if (reg_wr || reg_rd) begin
        obs_addr.push_back(reg_addr);
        obs_data.push_back(reg_wr ? reg_wdata : 8'h00);
        if (expq.size() == 0) begin
          check("unexpected_strobe", {reg_wr, reg_rd, reg_addr}, 0);
        end else begin
          e = expq.pop_front();
          check("strobe_kind", 32'(reg_wr), 32'(e.is_wr));
          check("strobe_addr", 32'(reg_addr), 32'(e.addr));
          if (e.is_wr) check("strobe_wdata", 32'(reg_wdata), 32'(e.data));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic miso_b);
    spi_mosi = b;
    wait_clk(HALF);
    miso_b  = spi_miso;
    spi_clk = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rxb[i] = m;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  // Frame-level model: one strobe per word, reads prefetch one extra word.
  task automatic model_frame(input logic [7:0] hdr, input int n, input logic [7:0] w[3]);
    exp_t e;
    logic [3:0] a;
    a = hdr[3:0];
    for (int i = 0; i < n; i++) begin
      e.is_wr = hdr[7];
      e.addr  = a;
      e.data  = hdr[7] ? w[i] : 8'h00;
      expq.push_back(e);
      if (!hdr[7]) exp_rx.push_back(8'(a * 8'h11));
      if (hdr[6]) a = a + 4'd1;
    end
    if (!hdr[7]) begin
      e.is_wr = 1'b0;
      e.addr  = a;
      e.data  = 8'h00;
      expq.push_back(e);
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input int n, input logic [7:0] w[3]);
    logic [7:0] rxb;
    obs_addr.delete();
    obs_data.delete();
    rx_words.delete();
    exp_rx.delete();
    model_frame(hdr, n, w);
    in_write = hdr[7];
    cs_low();
    spi_byte(hdr, rxb);
    check("busy_in_frame", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      spi_byte(hdr[7] ? w[i] : 8'h00, rxb);
      rx_words.push_back(rxb);
    end
    cs_high();
    in_write = 1'b0;
    check("frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
    check("busy_after", 32'(busy), 0);
    check("strobes_drained", 32'(expq.size()), 0);
    if (!hdr[7])
      for (int i = 0; i < n; i++) check("miso_word", 32'(rx_words[i]), 32'(exp_rx[i]));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {spi_miso, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err, busy}, 0);
  endtask

  initial begin
    logic [7:0] rxb;
    logic m;
    rst = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    wait_clk(3);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    wait_clk(8);

    run_frame(8'hC3, 2, '{8'hA5, 8'h5A, 8'h00});
    check("f1_a0", 32'(obs_addr[0]), 3);
    check("f1_d0", 32'(obs_data[0]), 32'hA5);
    check("f1_a1", 32'(obs_addr[1]), 4);
    check("f1_d1", 32'(obs_data[1]), 32'h5A);

    run_frame(8'hCF, 2, '{8'h11, 8'h22, 8'h00});
    check("f2_a0", 32'(obs_addr[0]), 32'hF);
    check("f2_a1_wrap", 32'(obs_addr[1]), 0);

    run_frame(8'h45, 2, '{8'h00, 8'h00, 8'h00});
    check("f3_miso0", 32'(rx_words[0]), 32'h55);
    check("f3_miso1", 32'(rx_words[1]), 32'h66);
    check("f3_rd_a0", 32'(obs_addr[0]), 5);
    check("f3_rd_a1", 32'(obs_addr[1]), 6);

    run_frame(8'h82, 3, '{8'h01, 8'h02, 8'h03});
    check("f4_count", 32'(obs_addr.size()), 3);
    for (int i = 0; i < 3; i++) check("f4_fixed_addr", 32'(obs_addr[i]), 2);

    run_frame(8'hC3, 0, '{8'h00, 8'h00, 8'h00});
    check("hdr_only_no_strobe", 32'(obs_addr.size()), 0);

    // Abort after 5 data bits of a write.
    ferr_exp++;
    in_write = 1'b1;
    cs_low();
    spi_byte(8'hC3, rxb);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    cs_high();
    in_write = 1'b0;
    check("abort_data_ferr", 32'(ferr_seen), 32'(ferr_exp));
    check("abort_data_busy", 32'(busy), 0);

    // Abort after 3 header bits.
    ferr_exp++;
    cs_low();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    cs_high();
    check("abort_hdr_ferr", 32'(ferr_seen), 32'(ferr_exp));
    check("abort_hdr_busy", 32'(busy), 0);

    // Reset mid-word with cs_n held low; later sclk edges must be ignored.
    cs_low();
    spi_byte(8'hC0, rxb);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    rst = 1'b1;
    wait_clk(1);
    check_all_zero("mid_reset_cycle1");
    wait_clk(1);
    check_all_zero("mid_reset_cycle2");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) spi_bit(i[0], m);
    check_all_zero("post_reset_ignored");
    check("post_reset_no_ferr", 32'(ferr_seen), 32'(ferr_exp));
    cs_high();
    check("post_reset_cs_rise_no_ferr", 32'(ferr_seen), 32'(ferr_exp));

    run_frame(8'hC0, 1, '{8'h7E, 8'h00, 8'h00});
    check("f7_count", 32'(obs_addr.size()), 1);
    check("f7_addr", 32'(obs_addr[0]), 0);
    check("f7_data", 32'(obs_data[0]), 32'h7E);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
